// File: rtl/uart_apb_regfile_if.sv
// rtl/uart_apb_regfile_if.sv - APB bus bundle between the CPU bridge and the UART register file
// The master drives the request side; the slave returns read data and the response.
interface uart_apb_regfile_if;
  logic        pSel;
  logic        pEnable;
  logic        pWrite;
  logic [7:0]  pAddr;
  logic [31:0] pWdata;
  logic [31:0] pRdata;
  logic        pReady;
  logic        pSlvErr;

  modport master (
    output pSel, pEnable, pWrite, pAddr, pWdata,
    input  pRdata, pReady, pSlvErr
  );

  modport slave (
    input  pSel, pEnable, pWrite, pAddr, pWdata,
    output pRdata, pReady, pSlvErr
  );
endinterface

// File: rtl/uart_apb_regfile.sv
// rtl/uart_apb_regfile.sv - APB register file bridging the CPU to the UART TX/RX engines
// Holds TX/RX first-word-fall-through FIFOs, baud/frame config, sticky error flags and the IRQ.
module uart_apb_regfile #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int DIV_W    = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  uart_apb_regfile_if.slave apb,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_fe,
  input  logic              rx_pe,
  output logic [DIV_W-1:0]  baud_div,
  output logic              tx_en,
  output logic              rx_en,
  output logic [4:0]        frame_cfg,
  output logic              irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;

  localparam logic [5:0] A_TXDATA   = 6'd0;
  localparam logic [5:0] A_RXDATA   = 6'd1;
  localparam logic [5:0] A_BAUD     = 6'd2;
  localparam logic [5:0] A_CTRL     = 6'd3;
  localparam logic [5:0] A_STATUS   = 6'd4;
  localparam logic [5:0] A_INT_EN   = 6'd5;
  localparam logic [5:0] A_INT_STAT = 6'd6;
  localparam logic [5:0] A_THR      = 6'd7;

  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       tx_mem_d [TX_DEPTH];
  logic [TAW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TCW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       rx_mem_d [RX_DEPTH];
  logic [RAW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [6:0]       ctrl_q, ctrl_d;
  logic [6:0]       int_en_q, int_en_d;
  logic [6:0]       sticky_q, sticky_d;
  logic [7:0]       rx_thr_q, rx_thr_d, tx_thr_q, tx_thr_d;
  logic             irq_q, irq_d;

  logic        access, wr, rd, mapped;
  logic [5:0]  addr_w;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_pop, tx_push_req, tx_ovf, tx_push, tx_flush;
  logic        rx_req, rx_pop, rx_ovf, rx_push, rx_flush;
  logic [6:0]  sticky_set, int_stat, int_stat_d;
  logic [7:0]  rx_head, rx_mask;
  logic [31:0] status, prdata;
  logic        pslverr;
  logic        unused_ok;

  assign access = apb.pSel & apb.pEnable;
  assign wr     = access & apb.pWrite;
  assign rd     = access & ~apb.pWrite;
  assign addr_w = apb.pAddr[7:2];
  assign mapped = (addr_w <= A_THR);

  assign tx_full  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // A push into a full FIFO still succeeds when the head leaves in the same cycle.
  assign tx_valid    = ~tx_empty & ctrl_q[0];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr & (addr_w == A_TXDATA);
  assign tx_ovf      = tx_push_req & tx_full & ~tx_pop;
  assign tx_push     = tx_push_req & ~tx_ovf;
  assign tx_flush    = wr & (addr_w == A_CTRL) & apb.pWdata[8];

  assign rx_req   = rx_valid & ctrl_q[1];
  assign rx_pop   = rd & (addr_w == A_RXDATA) & ~rx_empty;
  assign rx_ovf   = rx_req & rx_full & ~rx_pop;
  assign rx_push  = rx_req & ~rx_ovf;
  assign rx_flush = wr & (addr_w == A_CTRL) & apb.pWdata[9];

  assign rx_head = rx_mem_q[rx_rptr_q];
  assign rx_mask = 8'hFF >> (2'd3 - ctrl_q[3:2]);

  assign int_stat = {sticky_q[6:2],
                     8'(tx_cnt_q) <= tx_thr_q,
                     (rx_thr_q != 8'd0) && (8'(rx_cnt_q) >= rx_thr_q)};
  assign status   = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                     tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = apb.pWdata[7:0];
        tx_wptr_d = tx_wptr_q + 1'b1;
      end
      if (tx_pop) tx_rptr_d = tx_rptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
    end
  end

  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = rx_data;
        rx_wptr_d = rx_wptr_q + 1'b1;
      end
      if (rx_pop) rx_rptr_d = rx_rptr_q + 1'b1;
      rx_cnt_d = rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_comb begin
    baud_d   = baud_q;
    ctrl_d   = ctrl_q;
    int_en_d = int_en_q;
    rx_thr_d = rx_thr_q;
    tx_thr_d = tx_thr_q;
    sticky_d = sticky_q;
    if (wr) begin
      case (addr_w)
        A_BAUD:     baud_d   = apb.pWdata[DIV_W-1:0];
        A_CTRL:     ctrl_d   = apb.pWdata[6:0];
        A_INT_EN:   int_en_d = apb.pWdata[6:0];
        A_INT_STAT: sticky_d = sticky_q & ~apb.pWdata[6:0];
        A_THR: begin
          rx_thr_d = apb.pWdata[15:8];
          tx_thr_d = apb.pWdata[7:0];
        end
        default: ;
      endcase
    end
    // Events are ORed in after the W1C so a same-cycle set survives the clear.
    sticky_set    = '0;
    sticky_set[2] = tx_pop & ~tx_flush & (tx_cnt_d == '0);
    sticky_set[3] = rx_ovf;
    sticky_set[4] = rx_req & rx_fe;
    sticky_set[5] = rx_req & rx_pe;
    sticky_set[6] = tx_ovf;
    sticky_d      = (sticky_d | sticky_set) & 7'h7C;
    int_stat_d    = {sticky_d[6:2],
                     8'(tx_cnt_d) <= tx_thr_d,
                     (rx_thr_d != 8'd0) && (8'(rx_cnt_d) >= rx_thr_d)};
    irq_d         = |(int_stat_d & int_en_d);
  end

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      if (!mapped) begin
        pslverr = 1'b1;
      end else if (rd) begin
        case (addr_w)
          A_RXDATA: begin
            if (rx_empty) pslverr = 1'b1;
            else          prdata  = {24'h0, rx_head & rx_mask};
          end
          A_BAUD:     prdata = 32'(baud_q);
          A_CTRL:     prdata = {25'h0, ctrl_q};
          A_STATUS:   prdata = status;
          A_INT_EN:   prdata = {25'h0, int_en_q};
          A_INT_STAT: prdata = {25'h0, int_stat};
          A_THR:      prdata = {16'h0, rx_thr_q, tx_thr_q};
          default:    prdata = '0;
        endcase
      end else if (tx_ovf) begin
        pslverr = 1'b1;
      end
    end
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      for (int i = 0; i < TX_DEPTH; i++) tx_mem_q[i] <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      baud_q    <= '0;
      ctrl_q    <= '0;
      int_en_q  <= '0;
      sticky_q  <= '0;
      rx_thr_q  <= '0;
      tx_thr_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      tx_mem_q  <= tx_mem_d;
      rx_mem_q  <= rx_mem_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      baud_q    <= baud_d;
      ctrl_q    <= ctrl_d;
      int_en_q  <= int_en_d;
      sticky_q  <= sticky_d;
      rx_thr_q  <= rx_thr_d;
      tx_thr_q  <= tx_thr_d;
      irq_q     <= irq_d;
    end
  end

  assign apb.pRdata  = prdata;
  assign apb.pSlvErr = pslverr;
  assign apb.pReady  = 1'b1;
  assign tx_data     = tx_mem_q[tx_rptr_q];
  assign baud_div    = baud_q;
  assign tx_en       = ctrl_q[0];
  assign rx_en       = ctrl_q[1];
  assign frame_cfg   = ctrl_q[6:2];
  assign irq         = irq_q;
  assign unused_ok   = ^{apb.pAddr[1:0], apb.pWdata};
endmodule

// File: tb/tb_uart_apb_regfile.sv
// tb/tb_uart_apb_regfile.sv - self-checking bench for uart_apb_regfile
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_uart_apb_regfile;
  localparam int D = 16;

  logic        pClk = 1'b0;
  logic        pReset;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_fe, rx_pe;
  logic [15:0] baud_div;
  logic        tx_en, rx_en, irq;
  logic [4:0]  frame_cfg;

  uart_apb_regfile_if apb_if ();

  uart_apb_regfile #(.TX_DEPTH(D), .RX_DEPTH(D), .DIV_W(16)) dut (
    .pClk(pClk), .pReset(pReset), .apb(apb_if),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_fe(rx_fe), .rx_pe(rx_pe),
    .baud_div(baud_div), .tx_en(tx_en), .rx_en(rx_en),
    .frame_cfg(frame_cfg), .irq(irq)
  );

  always #5 pClk = ~pClk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  byte unsigned txq[$];
  byte unsigned rxq[$];
  logic [15:0]  m_baud;
  logic [6:0]   m_ctrl, m_int_en, m_sticky;
  logic [7:0]   m_rx_thr, m_tx_thr;
  logic         m_irq;

  logic [31:0] obs_rdata;
  logic        obs_err, obs_txv;
  logic [7:0]  obs_txd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    txq.delete();
    rxq.delete();
    m_baud = '0; m_ctrl = '0; m_int_en = '0; m_sticky = '0;
    m_rx_thr = '0; m_tx_thr = '0; m_irq = 1'b0;
  endtask

  function automatic logic [6:0] m_stat_bits();
    logic [6:0] s;
    s    = m_sticky;
    s[0] = (m_rx_thr != 0) && (rxq.size() >= int'(m_rx_thr));
    s[1] = txq.size() <= int'(m_tx_thr);
    return s;
  endfunction

  function automatic bit m_tx_pop();
    return m_ctrl[0] && txq.size() > 0 && tx_ready;
  endfunction

  task automatic m_comb(output logic [31:0] rdv, output logic err);
    int a;
    a   = int'(apb_if.pAddr) / 4;
    rdv = '0;
    err = 1'b0;
    if (apb_if.pSel && apb_if.pEnable) begin
      if (a >= 8) err = 1'b1;
      else if (!apb_if.pWrite) begin
        case (a)
          1: if (rxq.size() == 0) err = 1'b1;
             else rdv = 32'(rxq[0]) & ((32'd1 << (5 + int'(m_ctrl[3:2]))) - 1);
          2: rdv = 32'(m_baud);
          3: rdv = 32'(m_ctrl);
          4: rdv = (32'(rxq.size()) << 16) | (32'(txq.size()) << 8)
                 | (32'(txq.size() == D) << 3) | (32'(txq.size() == 0) << 2)
                 | (32'(rxq.size() == D) << 1) | 32'(rxq.size() == 0);
          5: rdv = 32'(m_int_en);
          6: rdv = 32'(m_stat_bits());
          7: rdv = {16'h0, m_rx_thr, m_tx_thr};
          default: rdv = '0;
        endcase
      end else if (a == 0 && txq.size() == D && !m_tx_pop()) err = 1'b1;
    end
  endtask

  task automatic m_seq();
    int a, tsz, rsz;
    bit acc, wr, rd, txpop, txreq, txfl, rxfl, rxreq, rxpop;
    logic [6:0]  set;
    logic [31:0] wd;
    a     = int'(apb_if.pAddr) / 4;
    wd    = apb_if.pWdata;
    acc   = apb_if.pSel && apb_if.pEnable;
    wr    = acc && apb_if.pWrite && a < 8;
    rd    = acc && !apb_if.pWrite && a < 8;
    tsz   = txq.size();
    rsz   = rxq.size();
    txpop = m_tx_pop();
    txreq = wr && a == 0;
    txfl  = wr && a == 3 && wd[8];
    rxfl  = wr && a == 3 && wd[9];
    rxreq = rx_valid && m_ctrl[1];
    rxpop = rd && a == 1 && rsz > 0;
    set   = '0;
    if (txreq && tsz == D && !txpop) set[6] = 1'b1;
    if (rxreq && rsz == D && !rxpop) set[3] = 1'b1;
    if (rxreq && rx_fe) set[4] = 1'b1;
    if (rxreq && rx_pe) set[5] = 1'b1;
    if (txfl) txq.delete();
    else begin
      if (txpop) void'(txq.pop_front());
      if (txreq && !set[6]) txq.push_back(wd[7:0]);
      if (txpop && txq.size() == 0) set[2] = 1'b1;
    end
    if (rxfl) rxq.delete();
    else begin
      if (rxpop) void'(rxq.pop_front());
      if (rxreq && !set[3]) rxq.push_back(rx_data);
    end
    if (wr) begin
      case (a)
        2: m_baud   = wd[15:0];
        3: m_ctrl   = wd[6:0];
        5: m_int_en = wd[6:0];
        6: m_sticky = m_sticky & ~wd[6:0];
        7: begin m_rx_thr = wd[15:8]; m_tx_thr = wd[7:0]; end
        default: ;
      endcase
    end
    m_sticky = (m_sticky | set) & 7'h7C;
    m_irq    = |(m_stat_bits() & m_int_en);
  endtask

  // One clock cycle: inputs already applied at posedge+1; check mid-cycle, advance model, check after edge.
  task automatic tick();
    logic [31:0] er;
    logic        ee;
    #4;
    m_comb(er, ee);
    obs_rdata = apb_if.pRdata;
    obs_err   = apb_if.pSlvErr;
    obs_txv   = tx_valid;
    obs_txd   = tx_data;
    chk("prdata", apb_if.pRdata, er);
    chk("pslverr", 32'(apb_if.pSlvErr), 32'(ee));
    chk("pready", 32'(apb_if.pReady), 32'd1);
    chk("tx_valid", 32'(tx_valid), 32'(m_ctrl[0] && txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    m_seq();
    @(posedge pClk);
    #1;
    chk("irq", 32'(irq), 32'(m_irq));
    chk("baud_div", 32'(baud_div), 32'(m_baud));
    chk("ctrl_out", 32'({frame_cfg, rx_en, tx_en}), 32'(m_ctrl));
  endtask

  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d);
    apb_if.pSel = 1'b1; apb_if.pEnable = 1'b0; apb_if.pWrite = w;
    apb_if.pAddr = a; apb_if.pWdata = d;
    tick();
    apb_if.pEnable = 1'b1;
    tick();
    apb_if.pSel = 1'b0; apb_if.pEnable = 1'b0;
  endtask

  task automatic inject(input logic [7:0] d, input bit fe, input bit pe);
    rx_valid = 1'b1; rx_data = d; rx_fe = fe; rx_pe = pe;
    tick();
    rx_valid = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    pReset = 1'b1;
    apb_if.pSel = 1'b0; apb_if.pEnable = 1'b0; apb_if.pWrite = 1'b0;
    apb_if.pAddr = '0; apb_if.pWdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_fe = 1'b0; rx_pe = 1'b0;
    m_reset();
    repeat (3) @(posedge pClk);
    #1;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_prdata", apb_if.pRdata, 32'd0);
    chk("rst_pslverr", 32'(apb_if.pSlvErr), 32'd0);
    pReset = 1'b0;

    apb(1'b0, 8'h0C, 0);
    chk("rst_ctrl", obs_rdata, 32'h0);
    apb(1'b0, 8'h10, 0);
    chk("rst_status", obs_rdata, 32'h5);

    // TX overflow at depth+1, then drain in order
    apb(1'b1, 8'h0C, 32'h1);
    for (int i = 1; i <= 17; i++) apb(1'b1, 8'h00, 32'(i));
    chk("txovf_err", 32'(obs_err), 32'd1);
    apb(1'b0, 8'h18, 0);
    chk("txovf_flag", (obs_rdata >> 6) & 1, 32'd1);
    apb(1'b0, 8'h10, 0);
    chk("tx_cnt_full", (obs_rdata >> 8) & 8'hFF, 32'd16);
    tx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("tx_seq_valid", 32'(obs_txv), 32'd1);
      chk("tx_seq_data", 32'(obs_txd), 32'(i));
    end
    tx_ready = 1'b0;
    apb(1'b0, 8'h18, 0);
    chk("txdone_flag", (obs_rdata >> 2) & 1, 32'd1);

    // RX masking by data_len and empty read
    apb(1'b1, 8'h0C, 32'h2);
    inject(8'hFF, 1'b0, 1'b0);
    apb(1'b0, 8'h04, 0);
    chk("rx_mask5", obs_rdata, 32'h1F);
    apb(1'b0, 8'h04, 0);
    chk("rx_empty_data", obs_rdata, 32'h0);
    chk("rx_empty_err", 32'(obs_err), 32'd1);

    // RX overrun with framing error, irq and W1C
    for (int i = 0; i < 16; i++) inject(8'($urandom), 1'b0, 1'b0);
    inject(8'h55, 1'b1, 1'b0);
    apb(1'b0, 8'h18, 0);
    chk("ovr_fe_flags", obs_rdata & 32'h18, 32'h18);
    apb(1'b0, 8'h10, 0);
    chk("rx_cnt_full", (obs_rdata >> 16) & 8'hFF, 32'd16);
    apb(1'b1, 8'h14, 32'h18);
    chk("irq_ovr_on", 32'(irq), 32'd1);
    apb(1'b1, 8'h18, 32'h18);
    chk("irq_w1c_off", 32'(irq), 32'd0);
    apb(1'b1, 8'h0C, 32'h202);
    apb(1'b0, 8'h10, 0);
    chk("rx_flush_cnt", (obs_rdata >> 16) & 8'hFF, 32'd0);

    // Full TX: simultaneous push and pop, then flush during a pop
    apb(1'b1, 8'h18, 32'h7C);
    apb(1'b1, 8'h0C, 32'h1);
    for (int i = 0; i < 16; i++) apb(1'b1, 8'h00, 32'(8'hA0 + i));
    apb_if.pSel = 1'b1; apb_if.pEnable = 1'b0; apb_if.pWrite = 1'b1;
    apb_if.pAddr = 8'h00; apb_if.pWdata = 32'hAA;
    tick();
    apb_if.pEnable = 1'b1; tx_ready = 1'b1;
    tick();
    chk("full_pushpop_err", 32'(obs_err), 32'd0);
    tx_ready = 1'b0; apb_if.pSel = 1'b0; apb_if.pEnable = 1'b0;
    apb(1'b0, 8'h10, 0);
    chk("full_pushpop_cnt", (obs_rdata >> 8) & 8'hFF, 32'd16);
    apb(1'b0, 8'h18, 0);
    chk("full_pushpop_noovf", (obs_rdata >> 6) & 1, 32'd0);
    apb_if.pSel = 1'b1; apb_if.pEnable = 1'b0; apb_if.pWrite = 1'b1;
    apb_if.pAddr = 8'h0C; apb_if.pWdata = 32'h101;
    tick();
    apb_if.pEnable = 1'b1; tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; apb_if.pSel = 1'b0; apb_if.pEnable = 1'b0;
    apb(1'b0, 8'h10, 0);
    chk("tx_flush_cnt", (obs_rdata >> 8) & 8'hFF, 32'd0);

    // RX threshold interrupt
    apb(1'b1, 8'h0C, 32'h2);
    apb(1'b1, 8'h1C, 32'h0400);
    apb(1'b1, 8'h14, 32'h1);
    for (int i = 0; i < 3; i++) begin
      inject(8'(i + 1), 1'b0, 1'b0);
      chk("rxav_below", 32'(irq), 32'd0);
    end
    inject(8'h04, 1'b0, 1'b0);
    chk("rxav_irq_on", 32'(irq), 32'd1);
    apb(1'b0, 8'h04, 0);
    chk("rxav_irq_off", 32'(irq), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      logic [7:0] a;
      logic [31:0] wd;
      k = int'($urandom_range(0, 11));
      if (k < 8)       a = 8'(k * 4);
      else if (k < 10) a = 8'h00;
      else             a = 8'(32 + 4 * $urandom_range(0, 55));
      a = a | 8'($urandom_range(0, 3));
      wd = $urandom();
      if (a[7:2] == 6'd3)
        wd = {22'h0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              5'($urandom), 1'b1, ($urandom_range(0, 7) != 0)};
      else if (a[7:2] == 6'd7)
        wd = {16'h0, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))};
      apb_if.pSel    = ($urandom_range(0, 99) < 70);
      apb_if.pEnable = apb_if.pSel && ($urandom_range(0, 1) == 1);
      apb_if.pWrite  = ($urandom_range(0, 1) == 1);
      apb_if.pAddr   = a;
      apb_if.pWdata  = wd;
      tx_ready = ((i / 200) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      rx_fe    = ($urandom_range(0, 15) == 0);
      rx_pe    = ($urandom_range(0, 15) == 0);
      tick();
    end
    apb_if.pSel = 1'b0; apb_if.pEnable = 1'b0;
    rx_valid = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0; tx_ready = 1'b0;

    // Mid-operation asynchronous reset with a pending TX handshake and irq
    apb(1'b1, 8'h0C, 32'h3);
    apb(1'b1, 8'h00, 32'h5A);
    apb(1'b1, 8'h14, 32'h2);
    tx_ready = 1'b1;
    #2;
    pReset = 1'b1;
    #1;
    m_reset();
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_tx_en", 32'(tx_en), 32'd0);
    @(posedge pClk);
    #1;
    pReset = 1'b0;
    tx_ready = 1'b0;
    apb(1'b0, 8'h10, 0);
    chk("midrst_status", obs_rdata, 32'h5);
    apb(1'b0, 8'h24, 0);
    chk("unmapped_err", 32'(obs_err), 32'd1);
    chk("unmapped_data", obs_rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
